// File: rtl/logical_vec.sv
// Multi-lane bitwise logic unit: eight operators over LANES independent lanes,
// two-stage valid/ready pipeline with per-lane enable and per-lane zero flags.
module logical_vec #(
    parameter int SRC_WIDTH     = 32,
    parameter int OUT_WIDTH     = 32,
    parameter int LANES         = 4,
    parameter int CONTROL_WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*SRC_WIDTH-1:0]     src1,
    input  logic [LANES*SRC_WIDTH-1:0]     src2,
    input  logic [CONTROL_WIDTH-1:0]       control,
    input  logic [LANES-1:0]               lane_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*OUT_WIDTH-1:0]     out,
    output logic [LANES-1:0]               out_zero
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_ANDN = 3'd7
    } op_e;

    // Stage 1 holding registers
    logic                       s1_valid_reg;
    logic [LANES*SRC_WIDTH-1:0] s1_src1_reg;
    logic [LANES*SRC_WIDTH-1:0] s1_src2_reg;
    op_e                        s1_op_reg;
    logic [LANES-1:0]           s1_lane_en_reg;

    // Stage 2 (output) registers
    logic                       out_valid_reg;
    logic [LANES*OUT_WIDTH-1:0] out_reg;
    logic [LANES-1:0]           out_zero_reg;

    logic [LANES*OUT_WIDTH-1:0] out_next;
    logic [LANES-1:0]           out_zero_next;

    logic s2_free;
    logic s1_advance;
    logic accept;
    op_e  op_in;

    assign op_in      = op_e'(control[7:5]);
    assign s2_free    = !out_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_free;
    assign in_ready   = !s1_valid_reg || s2_free;
    assign accept     = in_valid && in_ready;

    // Only the operator field of the shared ALU control word matters here.
    generate
        if (CONTROL_WIDTH > 8) begin : g_ctl_hi
            logic unused_ctl_hi;
            assign unused_ctl_hi = ^control[CONTROL_WIDTH-1:8];
        end
    endgenerate
    logic unused_ctl_lo;
    assign unused_ctl_lo = ^control[4:0];

    // Stage 1: loads whenever it is empty or draining into stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            s1_src1_reg    <= src1;
            s1_src2_reg    <= src2;
            s1_op_reg      <= op_in;
            s1_lane_en_reg <= lane_en;
        end
    end

    // Per-lane operator evaluation from the stage 1 registers.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SRC_WIDTH-1:0] a;
            logic [SRC_WIDTH-1:0] b;
            logic [SRC_WIDTH-1:0] op_res;
            logic [SRC_WIDTH-1:0] lane_res;

            assign a = s1_src1_reg[gi*SRC_WIDTH +: SRC_WIDTH];
            assign b = s1_src2_reg[gi*SRC_WIDTH +: SRC_WIDTH];

            always_comb begin
                op_res = '0;
                case (s1_op_reg)
                    OP_NOT:  op_res = ~b;
                    OP_AND:  op_res = a & b;
                    OP_OR:   op_res = a | b;
                    OP_XOR:  op_res = a ^ b;
                    OP_NAND: op_res = ~(a & b);
                    OP_NOR:  op_res = ~(a | b);
                    OP_XNOR: op_res = ~(a ^ b);
                    OP_ANDN: op_res = a & ~b;
                    default: op_res = '0;
                endcase
            end

            // Disabled lanes pass operand A through untouched.
            assign lane_res = s1_lane_en_reg[gi] ? op_res : a;

            assign out_next[gi*OUT_WIDTH +: OUT_WIDTH] = lane_res;
            assign out_zero_next[gi]                   = ~|lane_res;
        end
    endgenerate

    // Stage 2: a new result replaces the old one in the same cycle it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_zero_reg  <= '0;
        end else if (s1_advance) begin
            out_valid_reg <= 1'b1;
            out_reg       <= out_next;
            out_zero_reg  <= out_zero_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign out_zero  = out_zero_reg;

endmodule

// File: tb/tb_logical_vec.sv
// Directed table vectors plus handshake sequences (stall, random traffic, reset
// flush) for logical_vec with LANES=4, 32-bit lanes.
module tb_logical_vec;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int CW = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [L*W-1:0]    src1;
    logic [L*W-1:0]    src2;
    logic [CW-1:0]     control;
    logic [L-1:0]      lane_en;
    logic              out_valid;
    logic              out_ready;
    logic [L*W-1:0]    out;
    logic [L-1:0]      out_zero;

    int checks = 0;
    int errors = 0;

    logical_vec #(.SRC_WIDTH(W), .OUT_WIDTH(W), .LANES(L), .CONTROL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .control(control), .lane_en(lane_en),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [CW-1:0]  ctl;
        logic [L-1:0]   en;
        logic [L*W-1:0] exp_out;
        logic [L-1:0]   exp_zero;
    } vec_t;

    typedef struct packed {
        logic [L*W-1:0] o;
        logic [L-1:0]   z;
    } res_t;

    res_t exp_q[$];

    function automatic logic [L*W-1:0] rep4(input logic [W-1:0] x);
        return {x, x, x, x};
    endfunction

    // Junk in the non-operator control bits must be ignored.
    function automatic logic [CW-1:0] mk_ctl(input logic [2:0] op);
        return {3'b101, op, 5'b10110};
    endfunction

    function automatic res_t model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                   input logic [CW-1:0] ctl, input logic [L-1:0] en);
        res_t r;
        logic [W-1:0] x, y, v;
        for (int i = 0; i < L; i++) begin
            x = a[i*W +: W];
            y = b[i*W +: W];
            case (ctl[7:5])
                3'd0: v = ~y;
                3'd1: v = x & y;
                3'd2: v = x | y;
                3'd3: v = x ^ y;
                3'd4: v = ~(x & y);
                3'd5: v = ~(x | y);
                3'd6: v = ~(x ^ y);
                default: v = x & ~y;
            endcase
            if (!en[i]) v = x;
            r.o[i*W +: W] = v;
            r.z[i] = (v == '0);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic: drive, observe handshakes before the edge, score.
    task automatic step(input logic iv, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                        input logic [CW-1:0] ctl, input logic [L-1:0] en, input logic ordy,
                        output logic acc, output logic hs, output logic rdy);
        res_t r;
        in_valid = iv; src1 = a; src2 = b; control = ctl; lane_en = en; out_ready = ordy;
        #1;
        rdy = in_ready;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {{(L*W-1){1'b0}}, out_valid}, '0);
            end else begin
                r = exp_q.pop_front();
                check("stream_out", out, r.o);
                check("stream_zero", (L*W)'(out_zero), (L*W)'(r.z));
            end
        end
        if (acc) exp_q.push_back(model(a, b, ctl, en));
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        logic acc, hs, rdy;
        int lat, sent, got, cyc, fall_at, s1_cnt;
        logic [L*W-1:0] ra, rb, first_out;
        logic [CW-1:0] rc;
        logic [L-1:0] re;
        res_t r0;

        // Hand-computed vector table
        vecs[0] = '{{32'hAAAAAAAA, 32'h00000000, 32'h12345678, 32'hFFFF0000},
                    {32'h55555555, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0F0F0F0F},
                    mk_ctl(3'd1), 4'hF,
                    {32'h00000000, 32'h00000000, 32'h12345678, 32'h0F0F0000}, 4'b1100};
        vecs[1] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd0), 4'hF, rep4(32'h00FF00FF), 4'b0000};
        vecs[2] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd1), 4'hF, rep4(32'hF000F000), 4'b0000};
        vecs[3] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd2), 4'hF, rep4(32'hFFF0FFF0), 4'b0000};
        vecs[4] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd3), 4'hF, rep4(32'h0FF00FF0), 4'b0000};
        vecs[5] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd4), 4'hF, rep4(32'h0FFF0FFF), 4'b0000};
        vecs[6] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd5), 4'hF, rep4(32'h000F000F), 4'b0000};
        vecs[7] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd6), 4'hF, rep4(32'hF00FF00F), 4'b0000};
        vecs[8] = '{rep4(32'hF0F0F0F0), rep4(32'hFF00FF00), mk_ctl(3'd7), 4'hF, rep4(32'h00F000F0), 4'b0000};
        vecs[9] = '{rep4(32'hDEADBEEF), rep4(32'hDEADBEEF), mk_ctl(3'd3), 4'b0101,
                    {32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000}, 4'b0101};
        vecs[10] = '{rep4(32'h00000000), rep4(32'h00000000), mk_ctl(3'd5), 4'hF, rep4(32'hFFFFFFFF), 4'b0000};
        vecs[11] = '{rep4(32'h00000000), rep4(32'hFFFFFFFF), mk_ctl(3'd0), 4'b0011, rep4(32'h00000000), 4'b1111};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; control = '0; lane_en = '0;
        tick(); tick();
        rst = 1'b0;

        check("reset_out_valid", (L*W)'(out_valid), '0);
        check("reset_out", out, '0);
        check("reset_out_zero", (L*W)'(out_zero), '0);
        check("reset_in_ready", (L*W)'(in_ready), (L*W)'(1'b1));

        // Table: one request at a time, latency counted in edges from presentation
        for (int v = 0; v < 12; v++) begin
            in_valid = 1'b1; src1 = vecs[v].a; src2 = vecs[v].b;
            control = vecs[v].ctl; lane_en = vecs[v].en; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", v), (L*W)'(lat), (L*W)'(2));
            check($sformatf("vec%0d_out", v), out, vecs[v].exp_out);
            check($sformatf("vec%0d_zero", v), (L*W)'(out_zero), (L*W)'(vecs[v].exp_zero));
        end
        tick();

        // Stall: 6 back-to-back requests, consumer blocked for 4 cycles
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; fall_at = -1;
        r0 = model(rep4(32'h10000000), rep4(32'h0F0F0F0F), mk_ctl(3'd0), 4'hF);
        while ((sent < 6 || exp_q.size() > 0) && cyc < 60) begin
            if (cyc >= 2 && cyc < 4 && out_valid)
                check("stall_hold_out", out, r0.o);
            step(sent < 6, rep4(32'h10000000 + W'(sent)), rep4(32'h0F0F0F0F),
                 mk_ctl(3'(sent % 8)), 4'hF, cyc >= 4, acc, hs, rdy);
            if (!rdy && fall_at < 0) fall_at = sent;
            if (acc) sent++;
            if (hs) got++;
            cyc++;
        end
        check("stall_in_ready_fall", (L*W)'(fall_at), (L*W)'(2));
        check("stall_all_out", (L*W)'(got), (L*W)'(6));

        // Random traffic against the scoreboard
        sent = 0; got = 0; cyc = 0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            s1_cnt = exp_q.size() - int'(out_valid);
            if (s1_cnt == 0)
                check("rand_in_ready_s1_empty", (L*W)'(in_ready), (L*W)'(1'b1));
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = CW'($urandom);
            re = L'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            step((sent < 1000) && ($urandom_range(0, 1) == 1), ra, rb, rc, re,
                 $urandom_range(0, 1) == 1, acc, hs, rdy);
            if (acc) sent++;
            if (hs) got++;
            cyc++;
        end
        check("rand_all_out", (L*W)'(got), (L*W)'(1000));

        // Reset with two requests in flight and a request offered during reset
        exp_q.delete();
        step(1'b1, rep4(32'h11111111), rep4(32'h22222222), mk_ctl(3'd2), 4'hF, 1'b0, acc, hs, rdy);
        step(1'b1, rep4(32'h33333333), rep4(32'h44444444), mk_ctl(3'd2), 4'hF, 1'b0, acc, hs, rdy);
        rst = 1'b1; in_valid = 1'b1; src1 = rep4(32'h55555555); src2 = rep4(32'h66666666);
        out_ready = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", (L*W)'(out_valid), '0);
        check("flush_out", out, '0);
        check("flush_out_zero", (L*W)'(out_zero), '0);
        check("flush_in_ready", (L*W)'(in_ready), (L*W)'(1'b1));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("flush_no_ghost", (L*W)'(out_valid), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
